// File: rtl/bus_pkg.sv
// Shared definitions for the two-master memory-mapped bus: address map,
// arbiter state encoding, device-select encoding and decode helpers.
package bus_pkg;

  // Address map of the shared bus
  localparam logic [11:0] MEM_BEGIN = 12'h000;
  localparam logic [11:0] MEM_END   = 12'h1ff;
  localparam logic [11:0] SW_DATA   = 12'h900;
  localparam logic [11:0] SW_STATUS = 12'h901;
  localparam logic [11:0] SEVENSEG  = 12'hb00;

  // Read data returned to a master whose access hit no device
  localparam logic [15:0] UNMAPPED_DATA = 16'hf345;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_SW   = 2'd2,
    SEL_SS7  = 2'd3
  } dev_sel_t;

  // Inclusive range test on a bus address
  function automatic logic addr_in_range(input logic [11:0] addr,
                                         input logic [11:0] lo,
                                         input logic [11:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/bus_arbiter2_if.sv
// Signal bundle between the two bus masters / device muxes and the arbiter.
// The arbiter uses the slave view; masters and devices use the master view.
interface bus_arbiter2_if;

  // Master request side
  logic [1:0]  m_req;
  logic [1:0]  m_lock;
  logic [1:0]  m_we;
  logic [11:0] m0_addr;
  logic [11:0] m1_addr;
  logic [15:0] m0_wdata;
  logic [15:0] m1_wdata;
  logic [1:0]  m_ack;
  logic [15:0] m_rdata;

  // Shared device side
  logic [11:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic [15:0] bus_rdata;
  logic        sel_mem;
  logic        sel_sw;
  logic        sel_ss7;
  logic        bus_err;
  logic        owner;

  modport slave (
    input  m_req, m_lock, m_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  bus_rdata,
    output m_ack, m_rdata,
    output bus_addr, bus_wdata, bus_we, sel_mem, sel_sw, sel_ss7, bus_err, owner
  );

  modport master (
    output m_req, m_lock, m_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output bus_rdata,
    input  m_ack, m_rdata,
    input  bus_addr, bus_wdata, bus_we, sel_mem, sel_sw, sel_ss7, bus_err, owner
  );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: maps a bus address onto the device it
// selects. Shared by the arbiter and the top-level read-data muxes.
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [11:0] addr_i,
  output dev_sel_t    sel_o
);

  // Priority decode of the address map; anything else is unmapped
  always_comb begin
    sel_o = SEL_NONE;
    if (addr_in_range(addr_i, MEM_BEGIN, MEM_END)) begin
      sel_o = SEL_MEM;
    end else if ((addr_i == SW_DATA) || (addr_i == SW_STATUS)) begin
      sel_o = SEL_SW;
    end else if (addr_i == SEVENSEG) begin
      sel_o = SEL_SS7;
    end else begin
      sel_o = SEL_NONE;
    end
  end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master round-robin bus arbiter. One single-cycle transfer per grant;
// a master holding lock may be re-granted back-to-back up to MAX_LOCK
// transfers, after which a waiting peer is guaranteed the next grant.
// All bus-facing strobes are registered at the grant edge so the device
// side sees a clean one-cycle access.
module bus_arbiter2
  import bus_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  bus_arbiter2_if.slave bus
);

  localparam int unsigned        CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);

  // Registered state and outputs
  arb_state_t        state_q,    state_d;
  logic              owner_q,    owner_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [11:0]       addr_q,     addr_d;
  logic [15:0]       wdata_q,    wdata_d;
  logic              bus_we_q,   bus_we_d;
  logic [1:0]        ack_q,      ack_d;
  dev_sel_t          sel_q,      sel_d;
  logic              err_q,      err_d;

  // Arbitration result for the current cycle
  logic              grant_s;
  logic              winner_s;
  logic [11:0]       win_addr_s;
  logic [15:0]       win_wdata_s;
  logic              win_we_s;
  dev_sel_t          win_sel_s;

  // Pick a winner: round robin from IDLE, or re-grant the locking owner
  always_comb begin
    grant_s    = 1'b0;
    winner_s   = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.m_req != 2'b00) begin
          grant_s    = 1'b1;
          lock_cnt_d = CNT_ONE;
          if (bus.m_req == 2'b11) begin
            winner_s = ~owner_q;
          end else begin
            winner_s = bus.m_req[1];
          end
        end else begin
          lock_cnt_d = CNT_ZERO;
        end
      end
      XFER: begin
        if (bus.m_lock[owner_q] && bus.m_req[owner_q] && (lock_cnt_q < CNT_MAX)) begin
          grant_s    = 1'b1;
          winner_s   = owner_q;
          lock_cnt_d = lock_cnt_q + CNT_ONE;
        end else begin
          lock_cnt_d = CNT_ZERO;
        end
      end
      default: begin
        grant_s    = 1'b0;
        lock_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // The winner's request fields, captured only at grant
  assign win_addr_s  = winner_s ? bus.m1_addr  : bus.m0_addr;
  assign win_wdata_s = winner_s ? bus.m1_wdata : bus.m0_wdata;
  assign win_we_s    = bus.m_we[winner_s];

  bus_addr_decode u_decode (
    .addr_i (win_addr_s),
    .sel_o  (win_sel_s)
  );

  // Next state and next registered outputs; strobes default low
  always_comb begin
    state_d  = IDLE;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bus_we_d = 1'b0;
    ack_d    = 2'b00;
    sel_d    = SEL_NONE;
    err_d    = 1'b0;
    if (grant_s) begin
      state_d  = XFER;
      owner_d  = winner_s;
      addr_d   = win_addr_s;
      wdata_d  = win_wdata_s;
      sel_d    = win_sel_s;
      err_d    = (win_sel_s == SEL_NONE);
      // Unmapped writes never reach the device side
      bus_we_d = win_we_s && (win_sel_s != SEL_NONE);
      ack_d    = winner_s ? 2'b10 : 2'b01;
    end else begin
      state_d  = IDLE;
    end
  end

  // State and output registers; reset drops every strobe at once
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      owner_q    <= 1'b1;
      lock_cnt_q <= CNT_ZERO;
      addr_q     <= 12'h000;
      wdata_q    <= 16'h0000;
      bus_we_q   <= 1'b0;
      ack_q      <= 2'b00;
      sel_q      <= SEL_NONE;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bus_we_q   <= bus_we_d;
      ack_q      <= ack_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
    end
  end

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.m_ack     = ack_q;
  assign bus.sel_mem   = (sel_q == SEL_MEM);
  assign bus.sel_sw    = (sel_q == SEL_SW);
  assign bus.sel_ss7   = (sel_q == SEL_SS7);
  assign bus.bus_err   = err_q;
  assign bus.owner     = owner_q;

  // Read data only meaningful alongside an ack; unmapped reads get a marker
  assign bus.m_rdata = (ack_q != 2'b00) ? (err_q ? UNMAPPED_DATA : bus.bus_rdata)
                                        : 16'h0000;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2 with a device model and a transfer scoreboard.
module tb_bus_arbiter2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter2_if bus ();

  bus_arbiter2 #(.MAX_LOCK(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Device model: RAM, switchbank, seven-segment register
  logic [15:0] ram [0:511];
  logic [15:0] ss7_q;

  always_comb begin
    if (bus.bus_addr <= 12'h1ff)       bus.bus_rdata = ram[bus.bus_addr[8:0]];
    else if (bus.bus_addr == 12'h900)  bus.bus_rdata = 16'h00c3;
    else if (bus.bus_addr == 12'h901)  bus.bus_rdata = 16'h0001;
    else if (bus.bus_addr == 12'hb00)  bus.bus_rdata = ss7_q;
    else                               bus.bus_rdata = 16'hdead;
  end

  always @(posedge clk) begin
    if (bus.bus_we && bus.sel_mem) ram[bus.bus_addr[8:0]] <= bus.bus_wdata;
    if (bus.bus_we && bus.sel_ss7) ss7_q <= bus.bus_wdata;
  end

  // Scoreboard of expected transfers, in expected grant order
  typedef struct {
    logic        m;
    logic [11:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        chk_rd;
    logic        err;
    logic [2:0]  sel;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic [11:0] a, input logic we,
                      input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    e.m      = m;
    e.addr   = a;
    e.we     = we;
    e.wdata  = wd;
    e.sel    = {(a <= 12'h1ff), ((a == 12'h900) || (a == 12'h901)), (a == 12'hb00)};
    e.err    = (e.sel == 3'b000);
    e.chk_rd = !we || e.err;
    e.rdata  = e.err ? 16'hf345 : rd;
    sbq.push_back(e);
  endtask

  // Monitor: every ack must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.m_ack != 2'b00) begin
        chk("ack_onehot", 32'(bus.m_ack != 2'b11), 32'd1);
        if (sbq.size() == 0) begin
          chk("sb_unexpected_ack", 32'(bus.m_ack), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("sb_master", 32'(bus.m_ack), mon_e.m ? 32'd2 : 32'd1);
          chk("sb_addr",   32'(bus.bus_addr), 32'(mon_e.addr));
          chk("sb_we",     32'(bus.bus_we), 32'(mon_e.we && !mon_e.err));
          chk("sb_err",    32'(bus.bus_err), 32'(mon_e.err));
          chk("sb_sel",    32'({bus.sel_mem, bus.sel_sw, bus.sel_ss7}), 32'(mon_e.sel));
          if (mon_e.we)     chk("sb_wdata", 32'(bus.bus_wdata), 32'(mon_e.wdata));
          if (mon_e.chk_rd) chk("sb_rdata", 32'(bus.m_rdata), 32'(mon_e.rdata));
        end
      end else begin
        chk("we_idle", 32'(bus.bus_we), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete handshake for a single master, bounded wait for the ack
  task automatic single(input logic m, input logic [11:0] a, input logic we,
                        input logic [15:0] wd, input logic [15:0] rd);
    logic got;
    push(m, a, we, wd, rd);
    if (m) begin
      bus.m1_addr  = a;
      bus.m1_wdata = wd;
    end else begin
      bus.m0_addr  = a;
      bus.m0_wdata = wd;
    end
    bus.m_we[m]  = we;
    bus.m_req[m] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (bus.m_ack[m]) got = 1'b1;
    end
    chk("single_ack_seen", 32'(got), 32'd1);
    bus.m_req[m] = 1'b0;
    bus.m_we[m]  = 1'b0;
    step();
  endtask

  logic [1:0] alt_pat  [7] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
  logic [1:0] lock_pat [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};

  initial begin
    reset        = 1'b1;
    bus.m_req    = 2'b00;
    bus.m_lock   = 2'b00;
    bus.m_we     = 2'b00;
    bus.m0_addr  = 12'h000;
    bus.m1_addr  = 12'h000;
    bus.m0_wdata = 16'h0000;
    bus.m1_wdata = 16'h0000;

    // Reset state
    #12;
    chk("rst_ack",     32'(bus.m_ack),     32'd0);
    chk("rst_we",      32'(bus.bus_we),    32'd0);
    chk("rst_sel",     32'({bus.sel_mem, bus.sel_sw, bus.sel_ss7}), 32'd0);
    chk("rst_err",     32'(bus.bus_err),   32'd0);
    chk("rst_addr",    32'(bus.bus_addr),  32'd0);
    chk("rst_wdata",   32'(bus.bus_wdata), 32'd0);
    chk("rst_owner",   32'(bus.owner),     32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Preload RAM through the arbiter
    single(1'b0, 12'h005, 1'b1, 16'h1234, 16'h0000);
    single(1'b0, 12'h010, 1'b1, 16'haaaa, 16'h0000);
    single(1'b1, 12'h011, 1'b1, 16'h5555, 16'h0000);
    single(1'b0, 12'h020, 1'b1, 16'h0c0c, 16'h0000);
    single(1'b1, 12'h021, 1'b1, 16'h3c3c, 16'h0000);
    single(1'b0, 12'h100, 1'b1, 16'h7777, 16'h0000);

    // m0 read of 0x005: ack in the cycle after the request cycle
    bus.m0_addr = 12'h005;
    bus.m_req   = 2'b01;
    push(1'b0, 12'h005, 1'b0, 16'h0000, 16'h1234);
    chk("lat_req_cycle", 32'(bus.m_ack), 32'd0);
    step();
    chk("lat_ack",   32'(bus.m_ack),   32'd1);
    chk("lat_addr",  32'(bus.bus_addr), 32'h005);
    chk("lat_rdata", 32'(bus.m_rdata), 32'h1234);
    bus.m_req = 2'b00;
    step();
    chk("lat_done", 32'(bus.m_ack), 32'd0);

    // Both requesting without lock: alternate with an idle bubble
    bus.m0_addr = 12'h010;
    bus.m1_addr = 12'h011;
    bus.m_req   = 2'b11;
    push(1'b1, 12'h011, 1'b0, 16'h0000, 16'h5555);
    push(1'b0, 12'h010, 1'b0, 16'h0000, 16'haaaa);
    push(1'b1, 12'h011, 1'b0, 16'h0000, 16'h5555);
    push(1'b0, 12'h010, 1'b0, 16'h0000, 16'haaaa);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("alt_ack", 32'(bus.m_ack), 32'(alt_pat[i]));
    end
    bus.m_req = 2'b00;
    step();
    chk("alt_end",   32'(bus.m_ack), 32'd0);
    chk("alt_owner", 32'(bus.owner), 32'd0);

    // m1 write to the seven-segment register
    bus.m1_addr  = 12'hb00;
    bus.m1_wdata = 16'h00ab;
    bus.m_we     = 2'b10;
    bus.m_req    = 2'b10;
    push(1'b1, 12'hb00, 1'b1, 16'h00ab, 16'h0000);
    step();
    chk("ss7_ack",   32'(bus.m_ack),     32'd2);
    chk("ss7_sel",   32'(bus.sel_ss7),   32'd1);
    chk("ss7_we",    32'(bus.bus_we),    32'd1);
    chk("ss7_wdata", 32'(bus.bus_wdata), 32'h00ab);
    bus.m_req = 2'b00;
    bus.m_we  = 2'b00;
    step();
    chk("ss7_we_pulse", 32'(bus.bus_we),  32'd0);
    chk("ss7_sel_off",  32'(bus.sel_ss7), 32'd0);
    chk("ss7_reg",      32'(ss7_q),       32'h00ab);

    // m0 locked with m1 waiting: four back-to-back m0 grants, then m1
    bus.m0_addr = 12'h020;
    bus.m1_addr = 12'h021;
    bus.m_lock  = 2'b01;
    bus.m_req   = 2'b11;
    for (int i = 0; i < 4; i++) push(1'b0, 12'h020, 1'b0, 16'h0000, 16'h0c0c);
    push(1'b1, 12'h021, 1'b0, 16'h0000, 16'h3c3c);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lock_ack", 32'(bus.m_ack), 32'(lock_pat[i]));
    end
    bus.m_req  = 2'b00;
    bus.m_lock = 2'b00;
    step();
    chk("lock_end",   32'(bus.m_ack), 32'd0);
    chk("lock_owner", 32'(bus.owner), 32'd1);

    // m0 write to unmapped 0x700: error pulse, write suppressed, ack given
    bus.m0_addr  = 12'h700;
    bus.m0_wdata = 16'hbeef;
    bus.m_we     = 2'b01;
    bus.m_req    = 2'b01;
    push(1'b0, 12'h700, 1'b1, 16'hbeef, 16'h0000);
    step();
    chk("unm_err",   32'(bus.bus_err), 32'd1);
    chk("unm_we",    32'(bus.bus_we),  32'd0);
    chk("unm_ack",   32'(bus.m_ack),   32'd1);
    chk("unm_rdata", 32'(bus.m_rdata), 32'hf345);
    bus.m_req = 2'b00;
    bus.m_we  = 2'b00;
    step();
    chk("unm_err_pulse", 32'(bus.bus_err), 32'd0);
    single(1'b0, 12'h100, 1'b0, 16'h0000, 16'h7777);

    // Map boundaries and the switchbank
    single(1'b1, 12'h901, 1'b0, 16'h0000, 16'h0001);
    single(1'b1, 12'h900, 1'b0, 16'h0000, 16'h00c3);
    single(1'b0, 12'h1ff, 1'b1, 16'h9abc, 16'h0000);
    single(1'b1, 12'h1ff, 1'b0, 16'h0000, 16'h9abc);
    single(1'b0, 12'h200, 1'b0, 16'h0000, 16'h0000);

    // Reset asserted in the middle of a write transfer
    bus.m0_addr  = 12'h040;
    bus.m0_wdata = 16'h1111;
    bus.m_we     = 2'b01;
    bus.m_req    = 2'b01;
    step();
    chk("rx_ack_before", 32'(bus.m_ack),  32'd1);
    chk("rx_we_before",  32'(bus.bus_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rx_ack",   32'(bus.m_ack),   32'd0);
    chk("rx_we",    32'(bus.bus_we),  32'd0);
    chk("rx_sel",   32'({bus.sel_mem, bus.sel_sw, bus.sel_ss7}), 32'd0);
    chk("rx_owner", 32'(bus.owner),   32'd1);
    chk("rx_addr",  32'(bus.bus_addr), 32'd0);
    bus.m_req = 2'b00;
    bus.m_we  = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // After reset the arbiter is idle and m0 wins a contested request
    bus.m0_addr = 12'h005;
    bus.m1_addr = 12'h010;
    bus.m_req   = 2'b11;
    push(1'b0, 12'h005, 1'b0, 16'h0000, 16'h1234);
    step();
    chk("post_rst_grant", 32'(bus.m_ack), 32'd1);
    bus.m_req = 2'b00;
    step();
    step();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
